// File: rtl/nibble_add_pkg.sv
// -----------------------------------------------------------------------------
// nibble_add_pkg
// Shared definitions for the nibble-serial adder sequencer.
//   state_e   : sequencer FSM states (IDLE, RUN, DONE)
//   NIBBLE    : width of the shared adder slice in bits
//   cnt_width : width of a step counter that must hold 0 .. steps-1
// -----------------------------------------------------------------------------
package nibble_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE = 4;

    // A one-step operation still needs a 1-bit counter so the register exists.
    function automatic int cnt_width(input int steps);
        int w;
        if (steps > 1) begin
            w = $clog2(steps);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_add_seq_rippleadd.sv
// -----------------------------------------------------------------------------
// rippleadd
// 4-bit ripple-carry adder slice shared by the sequencer.
// Ports:
//   cin  : carry in
//   a, b : 4-bit operands
//   cout : carry out of bit 3
//   sum  : 4-bit sum
// Purely combinational.
// -----------------------------------------------------------------------------
module rippleadd (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       cout,
    output logic [3:0] sum
);

    logic [4:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[4];

endmodule

// File: rtl/nibble_add_seq.sv
// -----------------------------------------------------------------------------
// nibble_add_seq
// Performs a WIDTH-bit add (a + b + cin) over WIDTH/4 cycles by passing one
// nibble per cycle through a single shared 4-bit rippleadd slice, least
// significant nibble first. The slice carry-out is registered and fed back as
// the next nibble's carry-in.
//
// Parameters:
//   WIDTH     : operand/result width, multiple of 4 and >= 4
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake carrying a, b, cin
//   out_valid/ out_ready: result handshake carrying sum, cout
//   busy                : high while an operation is in RUN or DONE
//   op_sub              : (only with NIBBLE_ADD_SEQ_SUB_EN) compute a - b;
//                         cout = 1 means no borrow, cin is ignored
//
// Optional feature macro: NIBBLE_ADD_SEQ_SUB_EN
//
// sum/cout are loaded only when an operation completes, so outside DONE they
// hold the last completed result (0 after reset); out_valid qualifies them.
// -----------------------------------------------------------------------------
module nibble_add_seq
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int STEPS = WIDTH / NIBBLE;
    localparam int CNT_W = cnt_width(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_width_check
        $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic               carry_r;
    logic [WIDTH-1:0]   result_r;
    logic [CNT_W-1:0]   step_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_e             next_state_s;
    logic               accept_s;
    logic               last_step_s;
    logic               in_ready_nx_s;
    logic               out_valid_nx_s;
    logic               busy_nx_s;
    logic [WIDTH-1:0]   b_load_s;
    logic               carry_load_s;
    logic [3:0]         slice_sum_s;
    logic               slice_cout_s;
    logic [WIDTH-1:0]   result_next_s;

    // ------------------------------------------------------------------
    // Shared adder slice: always sees the low nibble of the shifters
    // ------------------------------------------------------------------
    rippleadd u_slice (
        .cin  (carry_r),
        .a    (a_sh_r[NIBBLE-1:0]),
        .b    (b_sh_r[NIBBLE-1:0]),
        .cout (slice_cout_s),
        .sum  (slice_sum_s)
    );

    // New nibble enters at the top; after STEPS shifts the result is aligned.
    if (STEPS == 1) begin : g_result_single
        assign result_next_s = slice_sum_s;
    end else begin : g_result_multi
        assign result_next_s = {slice_sum_s, result_r[WIDTH-1:NIBBLE]};
    end

    // The bottom nibble of the result register is always shifted out unused.
    logic unused_s;
    assign unused_s = ^result_r[NIBBLE-1:0];

    // Operand/carry values captured at the accept edge
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    always_comb begin
        b_load_s     = b;
        carry_load_s = cin;
        if (op_sub) begin
            // a - b == a + ~b + 1; cin is ignored
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
    end
`else
    always_comb begin
        b_load_s     = b;
        carry_load_s = cin;
    end
`endif

    // Next-state decode and handshake qualification
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_step_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (step_r == LAST_STEP) begin
                    last_step_s  = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the next state so they can be registered
    always_comb begin
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
        busy_nx_s      = 1'b0;
        case (next_state_s)
            IDLE: begin
                in_ready_nx_s = 1'b1;
            end
            RUN: begin
                busy_nx_s = 1'b1;
            end
            DONE: begin
                out_valid_nx_s = 1'b1;
                busy_nx_s      = 1'b1;
            end
            default: begin
                in_ready_nx_s = 1'b0;
            end
        endcase
    end

    // State register and registered handshake/status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    // Datapath: operand shifters, carry, partial result, step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            step_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b_load_s;
                        carry_r <= carry_load_s;
                        step_r  <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    a_sh_r   <= a_sh_r >> NIBBLE;
                    b_sh_r   <= b_sh_r >> NIBBLE;
                    carry_r  <= slice_cout_s;
                    result_r <= result_next_s;
                    step_r   <= step_r + 1'b1;
                end
                default: begin
                    // DONE holds everything until the result is taken
                end
            endcase
        end
    end

    // Output result registers, loaded only on the completing step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else begin
            if (last_step_s) begin
                sum_r  <= result_next_s;
                cout_r <= slice_cout_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_nibble_add_seq.sv
// -----------------------------------------------------------------------------
// tb_nibble_add_seq
// Self-checking bench for nibble_add_seq (WIDTH=16). Expected results come from
// a plain-arithmetic reference of a + b + cin (or a - b with the subtract
// option), latency is counted in cycles against WIDTH/4.
// -----------------------------------------------------------------------------
module tb_nibble_add_seq;

    localparam int WIDTH = 16;
    localparam int STEPS = WIDTH / 4;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             op_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic c, input logic s);
        int unsigned r;
        if (s) r = int'(x) + (32'h1_0000 - int'(y));     // a + (2^16 - b) = a - b, bit16 = no borrow
        else   r = int'(x) + int'(y) + int'(c);
        return r[WIDTH:0];
    endfunction

    // Runs one operation; caller and task both sit at a falling edge.
    // chain=1 presents the next request (na/nb/nc/ns) while held in DONE.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tc, input logic ts, input int hold, input bit chain,
                         input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                         input logic nc, input logic ns);
        logic [WIDTH:0] exp;
        int waits;
        int lat;
        exp = ref_result(ta, tb_v, tc, ts);
        a = ta; b = tb_v; cin = tc; op_sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        waits = 0;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check_eq({tag, "_accept_wait"}, waits, 0);
        @(posedge clk);
        @(negedge clk);
        // Inputs after the accept edge must not matter
        in_valid = 1'($urandom);
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        op_sub = SUB_EN ? 1'($urandom) : 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            check_eq({tag, "_run_rdy_busy"}, {in_ready, busy}, 2'b01);
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, STEPS);
        check_eq({tag, "_sum"}, sum, exp[WIDTH-1:0]);
        check_eq({tag, "_cout"}, cout, exp[WIDTH]);
        check_eq({tag, "_done_rdy_busy"}, {in_ready, busy}, 2'b01);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (chain) begin
                a = na; b = nb; cin = nc; op_sub = ns; in_valid = 1'b1;
            end else begin
                in_valid = 1'($urandom);
            end
            @(negedge clk);
            check_eq({tag, "_hold_sum"}, sum, exp[WIDTH-1:0]);
            check_eq({tag, "_hold_cout"}, cout, exp[WIDTH]);
            check_eq({tag, "_hold_vld_rdy"}, {out_valid, in_ready}, 2'b10);
        end
        if (chain) begin
            a = na; b = nb; cin = nc; op_sub = ns; in_valid = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_post_vld_rdy_busy"}, {out_valid, in_ready, busy}, 3'b010);
        check_eq({tag, "_post_sum"}, sum, exp[WIDTH-1:0]);
        check_eq({tag, "_post_cout"}, cout, exp[WIDTH]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rc;
        logic rs;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {out_valid, cout, busy, in_ready}, 4'b0000);
        check_eq("reset_sum", sum, 0);
        rst_n = 1'b1;
        check_eq("reset_release_rdy", in_ready, 1'b0);
        @(negedge clk);
        check_eq("first_clk_rdy", in_ready, 1'b1);

        // Directed cases
        do_op("zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        do_op("aaaa", 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        do_op("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        do_op("ffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Backpressure with a pending request held during DONE
        do_op("bp", 16'h1357, 16'h2468, 1'b1, 1'b0, 5, 1'b1, 16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        do_op("bp_next", 16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Reset during RUN step 2
        a = 16'h5555; b = 16'h3333; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs", {out_valid, cout, busy, in_ready}, 4'b0000);
        check_eq("midrst_sum", sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_release_rdy", in_ready, 1'b0);
        @(negedge clk);
        check_eq("midrst_idle_rdy_busy", {in_ready, busy, out_valid}, 3'b100);
        do_op("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        if (SUB_EN) begin
            do_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            do_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        end

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rs = SUB_EN ? 1'($urandom) : 1'b0;
            do_op("rand", ra, rb, rc, rs, int'($urandom_range(0, 3)), 1'b0,
                  16'h0, 16'h0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Multi-cycle sequencer that performs a WIDTH-bit add by driving one 4-bit ripple-adder slice (rippleadd, ports cin,a,b,cout,sum) once per cycle, least-significant nibble first.
- The slice's carry-out is registered and fed back as the next nibble's carry-in.
- Sits between a requester and a consumer with valid/ready handshakes on both sides.
- Lets the wide adds in the datapath share one small adder slice instead of instantiating WIDTH-bit adders.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- STEPS, WIDTH/4, derived localparam, not overridable; number of slice passes per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- in_valid  input  1  request carries valid operands.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into the least-significant nibble.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the most-significant nibble.
- busy  output  1  high in RUN or DONE.
- Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- FSM states: IDLE, RUN, DONE. All registers are clocked on the rising edge of clk.
- Reset (rst_n low, asynchronous, any state including mid-RUN):
  - State goes to IDLE.
  - Operand shift registers, result register, carry register and step counter clear to 0.
  - Outputs while in reset: out_valid=0, sum=0, cout=0, busy=0, in_ready=0.
  - in_ready goes to 1 on the first clock after rst_n deasserts.
- IDLE:
  - in_ready=1.
  - On an edge where in_valid&&in_ready: latch a, b and cin into the A shift register, B shift register and carry register; clear the step counter; go to RUN.
- RUN (in_ready=0):
  - Each cycle the slice sees A[3:0], B[3:0] and the carry register.
  - At the edge:
    - the slice sum nibble shifts into the top of the result register (result >> 4 with the new nibble at [WIDTH-1:WIDTH-4]);
    - A and B shift right by 4;
    - the carry register takes the slice cout;
    - the step counter increments.
  - When the counter reaches STEPS-1, that edge also moves the FSM to DONE.
- DONE:
  - out_valid=1; sum=result register; cout=carry register. Both are held stable until the handshake completes.
  - On out_valid&&out_ready: go to IDLE.
  - in_ready stays 0 for that edge, so there is no same-cycle re-accept.
- Latency: the result is visible exactly STEPS cycles after the accept edge. Minimum initiation interval is STEPS+2 cycles.
- Ignored inputs:
  - in_valid during RUN or DONE (requester must hold; no drop or overwrite).
  - out_ready in IDLE or RUN.
  - a, b, cin after the accept edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no internal truncation.
- WIDTH%4!=0 or WIDTH<4: fails elaboration via a generate-time error.
- sum/cout outside DONE: hold the last completed result (0 after reset); only out_valid qualifies them.

Optional Feature:
- Macro: NIBBLE_ADD_SEQ_SUB_EN.
- Defined:
  - Adds input op_sub (1 bit), latched with the operands at accept.
  - When op_sub=1: B is latched inverted and the carry register is initialised to 1, so cin is ignored. The result is a - b; cout=1 means no borrow.
- Undefined: port absent; the block is add-only and identical to the above.

Decomposition:
- Shared package nibble_add_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparam NIBBLE=4.
- One sub-module: the existing rippleadd is instantiated once as the slice. No other hierarchy.

Test Plan:
- 0x0000 + 0x0000, cin=0, out_ready=1 -> out_valid exactly 4 cycles after the accept edge; sum=0x0000, cout=0.
- 0xAAAA + 0xAAAA, cin=0 -> sum=0x5554, cout=1.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1. Then 0xFFFF + 0xFFFF, cin=1 -> sum=0xFFFF, cout=1; covers full carry ripple across all nibbles.
- Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid held high on a new request -> sum/cout stable, in_ready=0 throughout. Release out_ready -> the new request is accepted one cycle after return to IDLE.
- Reset mid-operation: assert rst_n low in RUN step 2 -> all outputs 0 immediately, state IDLE. Next op 0x1234 + 0x1111 -> sum=0x2345, cout=0.
- With NIBBLE_ADD_SEQ_SUB_EN: 0x0005 - 0x0007 -> sum=0xFFFE, cout=0. 0x0007 - 0x0005 -> sum=0x0002, cout=1.
